// File: rtl/ysyx_23060025_ifu_prefetch_pkg.sv
// ysyx_23060025_ifu_prefetch_pkg: shared constants and FSM state encoding for the prefetching IFU
//   TYPE_I_EBREAK : ebreak instruction encoding; fetching stops once it is queued
//   PC_RESET_VAL  : default fetch PC after reset
//   ifu_state_e   : 2-bit IFU FSM state
package ysyx_23060025_ifu_prefetch_pkg;

    localparam logic [31:0] TYPE_I_EBREAK = 32'h0010_0073;
    localparam logic [31:0] PC_RESET_VAL  = 32'h8000_0000;

    typedef enum logic [1:0] {
        IFU_IDLE  = 2'd0,
        IFU_FETCH = 2'd1,
        IFU_DRAIN = 2'd2,
        IFU_HALT  = 2'd3
    } ifu_state_e;

endpackage

// File: rtl/ysyx_23060025_ifu_prefetch_if.sv
// ysyx_23060025_ifu_prefetch_if: IFU bus bundle (icache request port + IDU handshake)
//   icache : out_paddr/out_psel (IFU -> icache), out_pready/out_prdata (icache -> IFU)
//   IDU    : ifu_valid_o/if_inst_o/if_pc_o (IFU -> IDU), idu_ready_i (IDU -> IFU)
//   master : IFU side; slave : icache/IDU side
interface ysyx_23060025_ifu_prefetch_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();

    logic [ADDR_WIDTH-1:0] out_paddr;
    logic                  out_psel;
    logic                  out_pready;
    logic [DATA_WIDTH-1:0] out_prdata;
    logic                  ifu_valid_o;
    logic                  idu_ready_i;
    logic [DATA_WIDTH-1:0] if_inst_o;
    logic [ADDR_WIDTH-1:0] if_pc_o;

    modport master (
        output out_paddr, out_psel, ifu_valid_o, if_inst_o, if_pc_o,
        input  out_pready, out_prdata, idu_ready_i
    );

    modport slave (
        input  out_paddr, out_psel, ifu_valid_o, if_inst_o, if_pc_o,
        output out_pready, out_prdata, idu_ready_i
    );

endinterface

// File: rtl/ysyx_23060025_sync_fifo.sv
// ysyx_23060025_sync_fifo: synchronous FIFO with flush; head entry read straight from storage
//   clock/reset : clock, synchronous active-high reset
//   flush_i     : empty the FIFO; wins over push_i and pop_i
//   push_i/data_i : enqueue (ignored when full)
//   pop_i       : dequeue head (ignored when empty)
//   data_o      : head entry, zero while empty
//   full_o/empty_o/count_o : occupancy status
module ysyx_23060025_sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [CW-1:0]    cnt_q;
    logic             push_en, pop_en;

    assign full_o  = cnt_q == CW'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign push_en = push_i & ~full_o & ~flush_i;
    assign pop_en  = pop_i & ~empty_o & ~flush_i;
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_q + AW'(push_en);
            rd_q  <= rd_q + AW'(pop_en);
            cnt_q <= cnt_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clock) begin
        if (push_en) mem_q[wr_q] <= data_i;
    end

endmodule

// File: rtl/ysyx_23060025_ifu_prefetch.sv
// ysyx_23060025_ifu_prefetch: instruction fetch unit that prefetches sequentially into a {pc, inst} queue
//   clock/reset      : clock, synchronous active-high reset
//   redirect_valid_i : merged branch/jump/CSR redirect pulse; flushes the queue
//   redirect_pc_i    : redirect target
//   ifu_bus          : icache request port and IDU handshake (master side)
//   halt_o           : ebreak queued, fetching stopped until reset
//   fifo_count_o     : queue occupancy
module ysyx_23060025_ifu_prefetch
    import ysyx_23060025_ifu_prefetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter int                    FIFO_DEPTH = 4,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(PC_RESET_VAL)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          redirect_valid_i,
    input  logic [ADDR_WIDTH-1:0]         redirect_pc_i,
    ysyx_23060025_ifu_prefetch_if.master  ifu_bus,
    output logic                          halt_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_WIDTH-1:0] drain_pc_q, drain_pc_d;
    logic                  flush, push, pop, full, empty, room, is_ebreak;
    logic [ADDR_WIDTH+DATA_WIDTH-1:0] head;

    assign flush     = redirect_valid_i & (state_q != IFU_HALT);
    // A response that coincides with a redirect belongs to the old path and is dropped.
    assign push      = (state_q == IFU_FETCH) & ifu_bus.out_pready & ~flush;
    assign pop       = ~empty & ifu_bus.idu_ready_i;
    assign is_ebreak = ifu_bus.out_prdata == DATA_WIDTH'(TYPE_I_EBREAK);
    // Keep requesting only while the queue will still have a free slot after this cycle.
    assign room      = (fifo_count_o + CW'(push) - CW'(pop)) < CW'(FIFO_DEPTH);

    ysyx_23060025_sync_fifo #(
        .WIDTH(ADDR_WIDTH + DATA_WIDTH),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({ifu_bus.out_paddr, ifu_bus.out_prdata}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (fifo_count_o)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IFU_IDLE;
            fetch_pc_q <= RESET_PC;
            drain_pc_q <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            drain_pc_q <= drain_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        drain_pc_d = drain_pc_q;
        fetch_pc_d = flush ? redirect_pc_i : push ? fetch_pc_q + ADDR_WIDTH'(4) : fetch_pc_q;
        case (state_q)
            IFU_IDLE:  state_d = (flush || room) ? IFU_FETCH : IFU_IDLE;
            IFU_FETCH: begin
                if (flush) begin
                    // The in-flight request must still complete; remember its address for DRAIN.
                    state_d    = ifu_bus.out_pready ? IFU_FETCH : IFU_DRAIN;
                    drain_pc_d = fetch_pc_q;
                end else if (ifu_bus.out_pready) begin
                    state_d = is_ebreak ? IFU_HALT : room ? IFU_FETCH : IFU_IDLE;
                end
            end
            IFU_DRAIN: state_d = ifu_bus.out_pready ? IFU_FETCH : IFU_DRAIN;
            default:   state_d = IFU_HALT;
        endcase
    end

    assign ifu_bus.out_psel    = (state_q == IFU_FETCH) || (state_q == IFU_DRAIN);
    assign ifu_bus.out_paddr   = (state_q == IFU_DRAIN) ? drain_pc_q : fetch_pc_q;
    assign ifu_bus.ifu_valid_o = ~empty;
    assign ifu_bus.if_pc_o     = head[ADDR_WIDTH+DATA_WIDTH-1:DATA_WIDTH];
    assign ifu_bus.if_inst_o   = head[DATA_WIDTH-1:0];
    assign halt_o              = state_q == IFU_HALT;

    logic unused_full;
    assign unused_full = full;

endmodule

// File: tb/tb_ysyx_23060025_ifu_prefetch.sv
// tb_ysyx_23060025_ifu_prefetch: self-checking bench for the prefetching IFU
module tb_ysyx_23060025_ifu_prefetch;

    localparam logic [31:0] RST_PC = 32'h8000_0000;
    localparam logic [31:0] EBRK   = 32'h0010_0073;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt;
    logic [2:0]  count;
    logic        ebreak_on = 1'b0;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [31:0] last_inst = '0;

    ent_t sb[$];
    logic m_drain = 1'b0;
    logic m_halt = 1'b0;

    ysyx_23060025_ifu_prefetch_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    ysyx_23060025_ifu_prefetch dut (
        .clock            (clock),
        .reset            (reset),
        .redirect_valid_i (redirect),
        .redirect_pc_i    (redirect_pc),
        .ifu_bus          (bus),
        .halt_o           (halt),
        .fifo_count_o     (count)
    );

    always #5 clock = ~clock;

    // icache model: data derived from the address, ebreak planted at 0x8000_0008 on demand
    assign bus.out_prdata = (ebreak_on && bus.out_paddr == 32'h8000_0008) ? EBRK : bus.out_paddr ^ 32'h5A5A_1234;

    // scoreboard: expected entries pushed on accepted icache responses, popped on IDU handshakes
    always @(negedge clock) begin
        ent_t e;
        logic redir;
        if (reset) begin
            sb.delete();
            m_drain = 1'b0;
            m_halt  = 1'b0;
        end else begin
            checks++;
            if (bus.ifu_valid_o !== (sb.size() != 0)) begin
                failures++;
                $display("FAIL sb_valid got=%b exp=%b t=%0t", bus.ifu_valid_o, sb.size() != 0, $time);
            end
            checks++;
            if (count !== 3'(sb.size())) begin
                failures++;
                $display("FAIL sb_count got=%0d exp=%0d t=%0t", count, sb.size(), $time);
            end
            redir = redirect && !m_halt;
            if (bus.ifu_valid_o && bus.idu_ready_i && !redir) begin
                checks++;
                if (sb.size() == 0) begin
                    failures++;
                    $display("FAIL sb_pop_empty got_pc=%h exp=none t=%0t", bus.if_pc_o, $time);
                end else begin
                    e = sb.pop_front();
                    if ({bus.if_pc_o, bus.if_inst_o} !== e) begin
                        failures++;
                        $display("FAIL sb_entry got=%h/%h exp=%h/%h t=%0t", bus.if_pc_o, bus.if_inst_o, e.pc, e.inst, $time);
                    end
                    last_inst = bus.if_inst_o;
                    pops++;
                end
            end
            if (redir) begin
                sb.delete();
                if (bus.out_psel && !bus.out_pready && !m_drain) m_drain = 1'b1;
                else if (m_drain && bus.out_pready) m_drain = 1'b0;
            end else if (bus.out_psel && bus.out_pready) begin
                if (m_drain) m_drain = 1'b0;
                else begin
                    sb.push_back({bus.out_paddr, bus.out_prdata});
                    if (bus.out_prdata == EBRK) m_halt = 1'b1;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect = 1'b0;
        redirect_pc = '0;
        bus.out_pready = 1'b0;
        bus.idu_ready_i = 1'b0;
        ebreak_on = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clock);
        checks++;
        if ({bus.out_psel, bus.out_paddr, bus.ifu_valid_o, bus.if_inst_o, bus.if_pc_o, halt, count} !==
            {1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL reset_state got psel=%b paddr=%h valid=%b inst=%h pc=%h halt=%b cnt=%0d exp 0/80000000/0/0/0/0/0",
                     bus.out_psel, bus.out_paddr, bus.ifu_valid_o, bus.if_inst_o, bus.if_pc_o, halt, count);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b1 || bus.out_paddr !== RST_PC) begin
            failures++;
            $display("FAIL first_req got psel=%b paddr=%h exp psel=1 paddr=%h", bus.out_psel, bus.out_paddr, RST_PC);
        end
    endtask

    task automatic test_stream();
        int p0;
        do_reset();
        bus.out_pready = 1'b1;
        bus.idu_ready_i = 1'b1;
        p0 = pops;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (k >= 1) begin
                checks++;
                if (bus.out_paddr !== RST_PC + 32'(4 * (k - 1))) begin
                    failures++;
                    $display("FAIL stream_paddr k=%0d got=%h exp=%h", k, bus.out_paddr, RST_PC + 32'(4 * (k - 1)));
                end
            end
            if (k >= 2) begin
                checks++;
                if (bus.ifu_valid_o !== 1'b1) begin
                    failures++;
                    $display("FAIL stream_valid k=%0d got=%b exp=1", k, bus.ifu_valid_o);
                end
            end
            next_cycle();
        end
        checks++;
        if (pops - p0 !== 8) begin
            failures++;
            $display("FAIL stream_rate got=%0d exp=8", pops - p0);
        end
        bus.out_pready = 1'b0;
        bus.idu_ready_i = 1'b0;
    endtask

    task automatic test_full();
        int fires = 0;
        do_reset();
        bus.out_pready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (bus.out_psel && bus.out_pready) fires++;
            next_cycle();
        end
        checks++;
        if (fires !== 4) begin
            failures++;
            $display("FAIL full_pushes got=%0d exp=4", fires);
        end
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b0 || count !== 3'd4) begin
            failures++;
            $display("FAIL full_stall got psel=%b cnt=%0d exp psel=0 cnt=4", bus.out_psel, count);
        end
        next_cycle();
        bus.idu_ready_i = 1'b1;
        @(negedge clock);
        next_cycle();
        bus.idu_ready_i = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b1 || bus.out_paddr !== 32'h8000_0010) begin
            failures++;
            $display("FAIL full_resume got psel=%b paddr=%h exp psel=1 paddr=80000010", bus.out_psel, bus.out_paddr);
        end
        next_cycle();
        bus.out_pready = 1'b0;
    endtask

    task automatic test_redirect_drain();
        do_reset();
        next_cycle();
        bus.out_pready = 1'b1;
        next_cycle();
        next_cycle();
        bus.out_pready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0100;
        next_cycle();
        redirect = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b1 || bus.out_paddr !== 32'h8000_0008 || bus.ifu_valid_o !== 1'b0 || count !== 3'd0) begin
            failures++;
            $display("FAIL drain_hold got psel=%b paddr=%h valid=%b cnt=%0d exp 1/80000008/0/0", bus.out_psel, bus.out_paddr, bus.ifu_valid_o, count);
        end
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus.out_paddr !== 32'h8000_0008) begin
            failures++;
            $display("FAIL drain_hold2 got=%h exp=80000008", bus.out_paddr);
        end
        next_cycle();
        bus.out_pready = 1'b1;
        next_cycle();
        bus.out_pready = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b1 || bus.out_paddr !== 32'h8000_0100 || bus.ifu_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL drain_exit got psel=%b paddr=%h valid=%b exp 1/80000100/0", bus.out_psel, bus.out_paddr, bus.ifu_valid_o);
        end
        next_cycle();
        bus.out_pready = 1'b1;
        next_cycle();
        bus.out_pready = 1'b0;
        @(negedge clock);
        checks++;
        if (bus.ifu_valid_o !== 1'b1 || bus.if_pc_o !== 32'h8000_0100) begin
            failures++;
            $display("FAIL drain_target got valid=%b pc=%h exp 1/80000100", bus.ifu_valid_o, bus.if_pc_o);
        end
    endtask

    task automatic test_redirect_pop();
        do_reset();
        next_cycle();
        bus.out_pready = 1'b1;
        next_cycle();
        next_cycle();
        bus.idu_ready_i = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h8000_0200;
        next_cycle();
        redirect = 1'b0;
        bus.out_pready = 1'b0;
        bus.idu_ready_i = 1'b0;
        @(negedge clock);
        checks++;
        if (count !== 3'd0 || bus.ifu_valid_o !== 1'b0 || bus.out_psel !== 1'b1 || bus.out_paddr !== 32'h8000_0200) begin
            failures++;
            $display("FAIL redir_pop got cnt=%0d valid=%b psel=%b paddr=%h exp 0/0/1/80000200", count, bus.ifu_valid_o, bus.out_psel, bus.out_paddr);
        end
    endtask

    task automatic test_ebreak();
        do_reset();
        ebreak_on = 1'b1;
        next_cycle();
        bus.out_pready = 1'b1;
        repeat (3) next_cycle();
        @(negedge clock);
        checks++;
        if (halt !== 1'b1 || bus.out_psel !== 1'b0 || count !== 3'd3) begin
            failures++;
            $display("FAIL ebreak_halt got halt=%b psel=%b cnt=%0d exp 1/0/3", halt, bus.out_psel, count);
        end
        next_cycle();
        redirect = 1'b1;
        redirect_pc = 32'h8000_0300;
        next_cycle();
        redirect = 1'b0;
        @(negedge clock);
        checks++;
        if (halt !== 1'b1 || bus.out_psel !== 1'b0 || count !== 3'd3 || bus.if_pc_o !== RST_PC) begin
            failures++;
            $display("FAIL ebreak_redir got halt=%b psel=%b cnt=%0d pc=%h exp 1/0/3/80000000", halt, bus.out_psel, count, bus.if_pc_o);
        end
        next_cycle();
        bus.idu_ready_i = 1'b1;
        repeat (3) next_cycle();
        bus.idu_ready_i = 1'b0;
        @(negedge clock);
        checks++;
        if (last_inst !== EBRK || count !== 3'd0 || halt !== 1'b1 || bus.out_psel !== 1'b0) begin
            failures++;
            $display("FAIL ebreak_drain got last=%h cnt=%0d halt=%b psel=%b exp %h/0/1/0", last_inst, count, halt, bus.out_psel, EBRK);
        end
        bus.out_pready = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        next_cycle();
        bus.out_pready = 1'b1;
        next_cycle();
        next_cycle();
        bus.out_pready = 1'b0;
        reset = 1'b1;
        next_cycle();
        @(negedge clock);
        checks++;
        if ({bus.out_psel, bus.out_paddr, bus.ifu_valid_o, bus.if_inst_o, bus.if_pc_o, halt, count} !==
            {1'b0, RST_PC, 1'b0, 32'h0, 32'h0, 1'b0, 3'd0}) begin
            failures++;
            $display("FAIL midreset_state got psel=%b paddr=%h valid=%b inst=%h pc=%h halt=%b cnt=%0d exp 0/80000000/0/0/0/0/0",
                     bus.out_psel, bus.out_paddr, bus.ifu_valid_o, bus.if_inst_o, bus.if_pc_o, halt, count);
        end
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        next_cycle();
        @(negedge clock);
        checks++;
        if (bus.out_psel !== 1'b1 || bus.out_paddr !== RST_PC) begin
            failures++;
            $display("FAIL midreset_restart got psel=%b paddr=%h exp 1/%h", bus.out_psel, bus.out_paddr, RST_PC);
        end
    endtask

    initial begin
        bus.out_pready = 1'b0;
        bus.idu_ready_i = 1'b0;
        test_reset();
        test_stream();
        test_full();
        test_redirect_drain();
        test_redirect_pop();
        test_ebreak();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
